// File: rtl/pe_eject_buf_pkg.sv
// Shared widths, flit type codes and FSM states for the PE ejection buffer.
// Flit type sits in the top two bits of every flit.
package pe_eject_buf_pkg;

  localparam int unsigned DATAW     = 15;
  localparam int unsigned VCH       = 1;
  localparam int unsigned VCHW      = 0;
  localparam int unsigned FLIT_W    = DATAW + 1;
  localparam int unsigned NVC       = VCH + 1;
  localparam int unsigned VC_W      = VCHW + 1;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned TYPE_MSB  = FLIT_W - 1;
  localparam int unsigned TYPE_LSB  = FLIT_W - 2;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic flit_type_e flit_type(input flit_t f);
    return flit_type_e'(f[TYPE_MSB:TYPE_LSB]);
  endfunction

  function automatic logic is_head(input flit_t f);
    return (flit_type(f) == FLIT_HEAD) || (flit_type(f) == FLIT_SINGLE);
  endfunction

  function automatic logic is_tail(input flit_t f);
    return (flit_type(f) == FLIT_TAIL) || (flit_type(f) == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/pe_eject_buf_if.sv
// Router-side flit input, per-VC ready, and PE-side valid/ready output bundle.
// master = router/PE side driver, slave = the ejection buffer.
interface pe_eject_buf_if;
    import pe_eject_buf_pkg::*;

    logic [FLIT_W-1:0] idata;
    logic              ivalid;
    logic [VC_W-1:0]   ivch;
    logic [NVC-1:0]    ordy;
    logic [FLIT_W-1:0] odata;
    logic              ovalid;
    logic [VC_W-1:0]   ovch;
    logic              oready;
    logic              err;

    modport master (
        output idata, ivalid, ivch, oready,
        input  ordy, odata, ovalid, ovch, err
    );

    modport slave (
        input  idata, ivalid, ivch, oready,
        output ordy, odata, ovalid, ovch, err
    );

endinterface

// File: rtl/pe_eject_buf_fifo.sv
// eject_fifo: single-VC first-word-fall-through FIFO; a push into a full FIFO
// is ignored even when a pop happens in the same cycle.
module eject_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/pe_eject_buf.sv
// pe_eject_buf: per-VC ejection FIFOs feeding the PE one whole packet at a time,
// round-robin at packet boundaries. `PE_EJECT_SAF_EN selects store-and-forward.
module pe_eject_buf
    import pe_eject_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input logic           clk,
    input logic           rst_,
    pe_eject_buf_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    flit_t           w_front [NVC];
    logic [CW-1:0]   w_count [NVC];
    logic [NVC-1:0]  w_full;
    logic [NVC-1:0]  w_empty;
    logic [NVC-1:0]  w_push;
    logic [NVC-1:0]  w_pop;
    logic [NVC-1:0]  w_ordy;
    logic [NVC-1:0]  w_elig;
    logic [NVC-1:0]  w_junk;
    logic [NVC-1:0]  w_rot;
    logic            w_found;
    logic            w_junk_hit;
    logic [VC_W-1:0] w_win;

    state_e          r_state;
    state_e          w_state_nx;
    logic [VC_W-1:0] r_sel;
    logic [VC_W-1:0] w_sel_nx;
    logic [VC_W-1:0] r_rr;
    logic [VC_W-1:0] w_rr_nx;
    logic            r_err;
    logic            w_err_nx;
    logic            w_ovalid;
    flit_t           w_odata;
    logic [VC_W-1:0] w_ovch;

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        eject_fifo #(
            .DEPTH (DEPTH),
            .W     (FLIT_W)
        ) u_fifo (
            .clk     (clk),
            .rst_    (rst_),
            .i_push  (w_push[v]),
            .i_data  (bus.idata),
            .i_pop   (w_pop[v]),
            .o_data  (w_front[v]),
            .o_count (w_count[v]),
            .o_full  (w_full[v]),
            .o_empty (w_empty[v])
        );
    end

`ifdef PE_EJECT_SAF_EN
    // Complete packets resident per VC; gates eligibility so bursts have no gaps.
    logic [CW-1:0] r_tails [NVC];

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NVC; v++) begin
            if (rst_) begin
                r_tails[v] <= '0;
            end else begin
                case ({w_push[v] && !w_full[v] && is_tail(bus.idata),
                       w_pop[v] && is_tail(w_front[v])})
                    2'b10:   r_tails[v] <= r_tails[v] + 1'b1;
                    2'b01:   r_tails[v] <= r_tails[v] - 1'b1;
                    default: ;
                endcase
            end
        end
    end
`endif

    always_comb begin
        w_push = '0;
        w_ordy = '0;
        w_elig = '0;
        w_junk = '0;
        for (int unsigned v = 0; v < NVC; v++) begin
            w_push[v] = bus.ivalid && (32'(bus.ivch) == v);
            w_ordy[v] = (w_count[v] < CW'(DEPTH));
            w_junk[v] = !w_empty[v] && !is_head(w_front[v]);
`ifdef PE_EJECT_SAF_EN
            w_elig[v] = !w_empty[v] && is_head(w_front[v]) && (r_tails[v] != '0);
`else
            w_elig[v] = !w_empty[v] && is_head(w_front[v]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_rr    <= VC_W'(VCH);
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_rr    <= w_rr_nx;
            r_err   <= w_err_nx;
        end
    end

    // Eligibility is rotated so bit 0 is the VC just after rr; the first set bit wins.
    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_rr_nx    = r_rr;
        w_pop      = '0;
        w_err_nx   = r_err | (|(w_push & w_full));
        w_ovalid   = 1'b0;
        w_odata    = '0;
        w_ovch     = '0;
        w_found    = 1'b0;
        w_junk_hit = 1'b0;
        w_win      = '0;
        w_rot      = NVC'({w_elig, w_elig} >> (32'(r_rr) + 1));
        case (r_state)
            ST_IDLE: begin
                for (int unsigned j = 0; j < NVC; j++) begin
                    if (!w_found && w_rot[j]) begin
                        w_found = 1'b1;
                        w_win   = VC_W'((32'(r_rr) + 1 + j) % NVC);
                    end
                end
                if (w_found) begin
                    w_sel_nx   = w_win;
                    w_state_nx = ST_XFER;
                end
                for (int unsigned v = 0; v < NVC; v++) begin
                    if (!w_junk_hit && w_junk[v]) begin
                        w_junk_hit = 1'b1;
                        w_pop[v]   = 1'b1;
                        w_err_nx   = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (!w_empty[r_sel]) begin
                    w_ovalid = 1'b1;
                    w_odata  = w_front[r_sel];
                    w_ovch   = r_sel;
                end
                if (w_ovalid && bus.oready) begin
                    w_pop[r_sel] = 1'b1;
                    if (is_tail(w_front[r_sel])) begin
                        w_rr_nx    = r_sel;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign bus.ordy   = w_ordy;
    assign bus.ovalid = w_ovalid;
    assign bus.odata  = w_odata;
    assign bus.ovch   = w_ovch;
    assign bus.err    = r_err;

endmodule
